gb_timer_gen: RTL



---
 rtl/gb_timer_pkg.sv | 27 ++
 rtl/gb_timer_divider.sv | 53 +++++
 rtl/gb_timer_gen.sv | 118 +++++++++++
 3 files changed

// File: rtl/gb_timer_pkg.sv
// Shared definitions for the DIV/TIMA/TMA/TAC timer: register offsets, TAC fields,
// TIMA state encoding and the TAC frequency to counter-bit mapping.
package gb_timer_pkg;

  localparam logic [1:0] OFS_DIV  = 2'd0;
  localparam logic [1:0] OFS_TIMA = 2'd1;
  localparam logic [1:0] OFS_TMA  = 2'd2;
  localparam logic [1:0] OFS_TAC  = 2'd3;

  localparam int TAC_W        = 3;
  localparam int TAC_EN_BIT   = 2;
  localparam int TAC_FREQ_LSB = 0;
  localparam int TAC_FREQ_MSB = 1;

  typedef enum logic [1:0] {RUN, OVF, RELD} tima_state_t;

  // Counter bit watched for each TAC frequency code; bits 7/1/3/5 when cnt_w is 14.
  function automatic int tap_index(input logic [1:0] freq, input int cnt_w);
    case (freq)
      2'b00:   tap_index = cnt_w - 7;
      2'b01:   tap_index = cnt_w - 13;
      2'b10:   tap_index = cnt_w - 11;
      default: tap_index = cnt_w - 9;
    endcase
  endfunction

endpackage

// File: rtl/gb_timer_divider.sv
// Free-running system counter with DIV clear, tap mux and falling-edge tick detector.
// tick is combinational from registered state; GB_TIMER_STOP_EN adds a counter hold input.
module gb_timer_divider
  import gb_timer_pkg::*;
#(
  parameter int CNT_W = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             div_wr,
`ifdef GB_TIMER_STOP_EN
  input  logic             stop,
`endif
  input  logic [TAC_W-1:0] tac,
  output logic [7:0]       div_val,
  output logic             tick
);

  localparam int TAP0 = tap_index(2'd0, CNT_W);
  localparam int TAP1 = tap_index(2'd1, CNT_W);
  localparam int TAP2 = tap_index(2'd2, CNT_W);
  localparam int TAP3 = tap_index(2'd3, CNT_W);

  logic [CNT_W-1:0] cnt;
  logic [3:0]       taps;
  logic             sel;
  logic             sel_q;

  assign taps    = {cnt[TAP3], cnt[TAP2], cnt[TAP1], cnt[TAP0]};
  assign sel     = taps[tac[TAC_FREQ_MSB:TAC_FREQ_LSB]] & tac[TAC_EN_BIT];
  // DIV writes and TAC changes that drop sel produce a tick on purpose (DMG glitch behaviour).
  assign tick    = sel_q & ~sel;
  assign div_val = cnt[CNT_W-1 -: 8];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      sel_q <= 1'b0;
    end else begin
      sel_q <= sel;
      if (div_wr)
        cnt <= '0;
`ifdef GB_TIMER_STOP_EN
      else if (!stop)
        cnt <= cnt + 1'b1;
`else
      else
        cnt <= cnt + 1'b1;
`endif
    end
  end

endmodule

// File: rtl/gb_timer_gen.sv
// DIV/TIMA/TMA/TAC timer on the CPU register bus: combinational reads, writes at the clk edge, no backpressure.
// TIMA overflow reads 00 for one cycle, then reloads TMA with irq_timer; GB_TIMER_STOP_EN adds stop_i.
module gb_timer_gen
  import gb_timer_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'hFF04,
  parameter int          CNT_W     = 14,
  parameter int          IRQ_PULSE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  data_i,
  input  logic [15:0] addr,
  input  logic        wren,
  input  logic        irq_ack,
`ifdef GB_TIMER_STOP_EN
  input  logic        stop_i,
`endif
  output logic [7:0]  data_o,
  output logic        sel_o,
  output logic        irq_timer
);

  logic [15:0]      ofs;
  logic             wr_div, wr_tima, wr_tma, wr_tac;
  logic [7:0]       tima, tma;
  logic [TAC_W-1:0] tac;
  logic [7:0]       div_val;
  logic             tick;
  logic             irq_set;
  tima_state_t      state;

  // Subtracting the base keeps the window check correct for any BASE_ADDR alignment.
  assign ofs     = addr - BASE_ADDR;
  assign sel_o   = (ofs < 16'd4);
  assign wr_div  = wren & sel_o & (ofs[1:0] == OFS_DIV);
  assign wr_tima = wren & sel_o & (ofs[1:0] == OFS_TIMA);
  assign wr_tma  = wren & sel_o & (ofs[1:0] == OFS_TMA);
  assign wr_tac  = wren & sel_o & (ofs[1:0] == OFS_TAC);
  assign irq_set = (state == OVF) & ~wr_tima;

  gb_timer_divider #(
    .CNT_W (CNT_W)
  ) u_divider (
    .clk     (clk),
    .reset   (reset),
    .div_wr  (wr_div),
`ifdef GB_TIMER_STOP_EN
    .stop    (stop_i),
`endif
    .tac     (tac),
    .div_val (div_val),
    .tick    (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= RUN;
      tima      <= 8'h00;
      tma       <= 8'h00;
      tac       <= '0;
      irq_timer <= 1'b0;
    end else begin
      if (wr_tma)
        tma <= data_i;
      if (wr_tac)
        tac <= data_i[TAC_W-1:0];

      case (state)
        RUN: begin
          if (wr_tima)
            tima <= data_i;
          else if (tick) begin
            if (tima == 8'hFF) begin
              tima  <= 8'h00;
              state <= OVF;
            end else
              tima <= tima + 8'd1;
          end
        end
        OVF: begin
          // A CPU write here cancels the reload and the interrupt.
          if (wr_tima) begin
            tima  <= data_i;
            state <= RUN;
          end else begin
            tima  <= tma;
            state <= RELD;
          end
        end
        RELD: begin
          if (wr_tma)
            tima <= data_i;
          state <= RUN;
        end
        default: state <= RUN;
      endcase

      if (IRQ_PULSE != 0)
        irq_timer <= irq_set;
      else
        irq_timer <= irq_set | (irq_timer & ~irq_ack);
    end
  end

  always_comb begin
    data_o = 8'hFF;
    if (sel_o) begin
      case (ofs[1:0])
        OFS_DIV:  data_o = div_val;
        OFS_TIMA: data_o = tima;
        OFS_TMA:  data_o = tma;
        default:  data_o = {5'b11111, tac};
      endcase
    end
  end

endmodule
